// File: rtl/mac_job_sequencer.sv
// Job-level sequencer for the shared FP8/FP4 SIMD MAC: accepts a dot-product job,
// clears the accumulator, streams operand pairs, drains the pipeline and holds the result.
module mac_job_sequencer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LAT     = 3,
  parameter int unsigned CLR_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid_i,
  output logic             job_ready_o,
  input  logic             job_mode_i,
  input  logic [CNT_W-1:0] job_len_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [7:0]       op_a_i,
  input  logic [7:0]       op_b_i,
  output logic [7:0]       mac_a_o,
  output logic [7:0]       mac_b_o,
  output logic             mac_sel_o,
  output logic             mac_clr_n_o,
  input  logic [7:0]       mac_out_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [7:0]       res_data_o,
  output logic             res_mode_o,
  output logic             busy_o
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PH_MAX = ((LAT + 1) > CLR_CYC) ? (LAT + 1) : CLR_CYC;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_RESULT
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PH_W-1:0]     ph_q;
  logic                job_ready_q;
  logic                op_ready_q;
  logic                busy_q;
  logic                mac_clr_n_q;
  logic                mac_sel_q;
  logic                res_valid_q;
  logic                res_mode_q;
  logic [DATA_W-1:0]   mac_a_q;
  logic [DATA_W-1:0]   mac_b_q;
  logic [DATA_W-1:0]   res_data_q;

  // Single-process FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ph_q        <= '0;
      job_ready_q <= 1'b1;
      op_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      mac_clr_n_q <= 1'b0;
      mac_sel_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_mode_q  <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_data_q  <= '0;
    end else begin
      // Operands default to zero so idle cycles add a zero product.
      mac_a_q <= '0;
      mac_b_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (job_valid_i && job_ready_q) begin
            state_q     <= S_CLEAR;
            mac_sel_q   <= job_mode_i;
            cnt_q       <= job_len_i;
            ph_q        <= '0;
            job_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (ph_q == PH_W'(CLR_CYC - 1)) begin
            ph_q        <= '0;
            mac_clr_n_q <= 1'b1;
            if (cnt_q == '0) begin
              state_q     <= S_RESULT;
              res_valid_q <= 1'b1;
              res_data_q  <= '0;
              res_mode_q  <= mac_sel_q;
            end else begin
              state_q    <= S_STREAM;
              op_ready_q <= 1'b1;
            end
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        S_STREAM: begin
          if (op_valid_i && op_ready_q) begin
            mac_a_q <= op_a_i;
            mac_b_q <= op_b_i;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q    <= S_DRAIN;
              op_ready_q <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Last drain cycle: the final product has reached mac_out.
          if (ph_q == PH_W'(LAT)) begin
            ph_q        <= '0;
            state_q     <= S_RESULT;
            res_valid_q <= 1'b1;
            res_data_q  <= mac_out_i;
            res_mode_q  <= mac_sel_q;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        S_RESULT: begin
          if (res_ready_i) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            mac_clr_n_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign job_ready_o = job_ready_q;
  assign op_ready_o  = op_ready_q;
  assign busy_o      = busy_q;
  assign mac_clr_n_o = mac_clr_n_q;
  assign mac_sel_o   = mac_sel_q;
  assign mac_a_o     = mac_a_q;
  assign mac_b_o     = mac_b_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_mode_o  = res_mode_q;

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a behavioural MAC stub (sum of products, LAT-cycle delay).
module tb_mac_job_sequencer;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LAT     = 3;
  localparam int unsigned CLR_CYC = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             job_valid, job_ready, job_mode;
  logic [CNT_W-1:0] job_len;
  logic             op_valid, op_ready;
  logic [7:0]       op_a, op_b, mac_a, mac_b, mac_out, res_data;
  logic             mac_sel, mac_clr_n, res_valid, res_ready, res_mode, busy;

  int passed = 0;
  int total  = 0;

  logic [7:0] tab_a [256];
  logic [7:0] tab_b [256];

  always #5 clk = ~clk;

  mac_job_sequencer #(.CNT_W(CNT_W), .LAT(LAT), .CLR_CYC(CLR_CYC)) dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid), .job_ready_o(job_ready), .job_mode_i(job_mode), .job_len_i(job_len),
    .op_valid_i(op_valid), .op_ready_o(op_ready), .op_a_i(op_a), .op_b_i(op_b),
    .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_sel_o(mac_sel), .mac_clr_n_o(mac_clr_n),
    .mac_out_i(mac_out),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .res_mode_o(res_mode),
    .busy_o(busy)
  );

  // MAC stub: operands present in cycle t appear in the sum on mac_out in cycle t+LAT.
  logic [7:0] acc_q;
  logic [7:0] dly_q [LAT-1];
  always_ff @(posedge clk) begin
    if (!mac_clr_n) begin
      acc_q <= '0;
      for (int k = 0; k < LAT - 1; k++) dly_q[k] <= '0;
    end else begin
      acc_q    <= acc_q + 8'(mac_a * mac_b);
      dly_q[0] <= acc_q;
      for (int k = 1; k < LAT - 1; k++) dly_q[k] <= dly_q[k-1];
    end
  end
  assign mac_out = dly_q[LAT-2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a job at the current cycle (cycle 0), feeds tab_a/tab_b, stops at the first RESULT cycle.
  task automatic run_job(input logic mode, input logic [7:0] len, input logic [63:0] bub,
                         output int res_cyc, output logic sel_ok, output logic opr_seen,
                         output logic bub_ok, output logic [15:0] first_ab);
    int   idx;
    logic prev_bub;
    res_cyc   = -1;
    sel_ok    = 1'b1;
    opr_seen  = 1'b0;
    bub_ok    = 1'b1;
    first_ab  = '0;
    idx       = 0;
    prev_bub  = 1'b0;
    job_valid = 1'b1;
    job_mode  = mode;
    job_len   = len;
    step();
    job_valid = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (mac_sel !== mode) sel_ok = 1'b0;
      if (op_ready) opr_seen = 1'b1;
      if (prev_bub && (mac_a !== 8'h00 || mac_b !== 8'h00)) bub_ok = 1'b0;
      if (cyc == int'(CLR_CYC) + 2) first_ab = {mac_a, mac_b};
      if (res_valid) begin
        res_cyc = cyc;
        break;
      end
      prev_bub = 1'b0;
      if (op_ready) begin
        if (cyc < 64 && bub[cyc]) begin
          op_valid = 1'b0;
          prev_bub = 1'b1;
        end else begin
          op_valid = 1'b1;
          op_a     = tab_a[idx];
          op_b     = tab_b[idx];
          idx++;
        end
      end else begin
        // Junk offered outside STREAM must be ignored.
        op_valid = 1'b1;
        op_a     = 8'hFF;
        op_b     = 8'hFF;
      end
      step();
    end
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    total++;
    if ({job_ready, op_ready, busy, mac_clr_n, mac_sel, res_valid, res_mode} !== 7'b1000000) begin
      $display("FAIL reset_ctrl got=%b exp=%b", {job_ready, op_ready, busy, mac_clr_n, mac_sel, res_valid, res_mode}, 7'b1000000);
    end else passed++;
    total++;
    if ({mac_a, mac_b, res_data} !== 24'h0) $display("FAIL reset_data got=%h exp=000000", {mac_a, mac_b, res_data});
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    total++;
    if (job_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_idle got=%b%b exp=10", job_ready, busy);
    else passed++;
  endtask

  task automatic test_fp8_basic();
    int res_cyc; logic sel_ok, opr, bub_ok; logic [15:0] fab;
    tab_a[0] = 8'd1; tab_b[0] = 8'd2; tab_a[1] = 8'd3; tab_b[1] = 8'd4;
    tab_a[2] = 8'd5; tab_b[2] = 8'd6; tab_a[3] = 8'd7; tab_b[3] = 8'd8;
    run_job(1'b0, 8'd4, 64'h0, res_cyc, sel_ok, opr, bub_ok, fab);
    total++;
    if (res_cyc != 11) $display("FAIL fp8_latency got=%0d exp=11", res_cyc); else passed++;
    total++;
    if (res_data !== 8'd100) $display("FAIL fp8_data got=%0d exp=100", res_data); else passed++;
    total++;
    if (res_mode !== 1'b0) $display("FAIL fp8_mode got=%b exp=0", res_mode); else passed++;
    total++;
    if (fab !== 16'h0102) $display("FAIL fp8_first_operands got=%h exp=0102", fab); else passed++;
    accept_result();
    total++;
    if (job_ready !== 1'b1 || res_valid !== 1'b0 || mac_clr_n !== 1'b0)
      $display("FAIL fp8_return_idle got=%b%b%b exp=100", job_ready, res_valid, mac_clr_n);
    else passed++;
  endtask

  task automatic test_bubbles();
    int res_cyc; logic sel_ok, opr, bub_ok; logic [15:0] fab;
    logic [63:0] bub;
    bub = '0;
    bub[4] = 1'b1;
    bub[6] = 1'b1;
    run_job(1'b0, 8'd4, bub, res_cyc, sel_ok, opr, bub_ok, fab);
    total++;
    if (res_cyc != 13) $display("FAIL bubble_latency got=%0d exp=13", res_cyc); else passed++;
    total++;
    if (res_data !== 8'd100) $display("FAIL bubble_data got=%0d exp=100", res_data); else passed++;
    total++;
    if (bub_ok !== 1'b1) $display("FAIL bubble_zero_operands got=%b exp=1", bub_ok); else passed++;
    accept_result();
  endtask

  task automatic test_fp4();
    int res_cyc; logic sel_ok, opr, bub_ok; logic [15:0] fab;
    tab_a[0] = 8'h12; tab_b[0] = 8'h03;
    tab_a[1] = 8'h21; tab_b[1] = 8'h02;
    run_job(1'b1, 8'd2, 64'h0, res_cyc, sel_ok, opr, bub_ok, fab);
    total++;
    if (res_cyc != 9) $display("FAIL fp4_latency got=%0d exp=9", res_cyc); else passed++;
    total++;
    if (sel_ok !== 1'b1) $display("FAIL fp4_sel_stable got=%b exp=1", sel_ok); else passed++;
    total++;
    if (res_mode !== 1'b1) $display("FAIL fp4_mode got=%b exp=1", res_mode); else passed++;
    total++;
    if (res_data !== 8'd120) $display("FAIL fp4_data got=%0d exp=120", res_data); else passed++;
    total++;
    if (fab !== 16'h1203) $display("FAIL fp4_lane_passthru got=%h exp=1203", fab); else passed++;
    accept_result();
  endtask

  task automatic test_len0();
    int res_cyc; logic sel_ok, opr, bub_ok; logic [15:0] fab;
    run_job(1'b0, 8'd0, 64'h0, res_cyc, sel_ok, opr, bub_ok, fab);
    total++;
    if (res_cyc != 3) $display("FAIL len0_latency got=%0d exp=3", res_cyc); else passed++;
    total++;
    if (res_data !== 8'h00) $display("FAIL len0_data got=%h exp=00", res_data); else passed++;
    total++;
    if (opr !== 1'b0) $display("FAIL len0_op_ready got=%b exp=0", opr); else passed++;
    accept_result();
  endtask

  task automatic test_back_pressure();
    int res_cyc; logic sel_ok, opr, bub_ok; logic [15:0] fab;
    logic hold_ok;
    tab_a[0] = 8'd1; tab_b[0] = 8'd2; tab_a[1] = 8'd3; tab_b[1] = 8'd4;
    tab_a[2] = 8'd5; tab_b[2] = 8'd6; tab_a[3] = 8'd7; tab_b[3] = 8'd8;
    run_job(1'b0, 8'd4, 64'h0, res_cyc, sel_ok, opr, bub_ok, fab);
    job_valid = 1'b1;
    job_mode  = 1'b1;
    job_len   = 8'd3;
    hold_ok   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (res_valid !== 1'b1 || res_data !== 8'd100 || res_mode !== 1'b0 ||
          job_ready !== 1'b0 || mac_sel !== 1'b0) hold_ok = 1'b0;
      step();
    end
    total++;
    if (hold_ok !== 1'b1) $display("FAIL bp_hold_stable got=%b exp=1", hold_ok); else passed++;
    accept_result();
    total++;
    if (job_ready !== 1'b1 || res_valid !== 1'b0 || mac_sel !== 1'b0)
      $display("FAIL bp_idle_no_accept got=%b%b%b exp=100", job_ready, res_valid, mac_sel);
    else passed++;
    step();
    job_valid = 1'b0;
    total++;
    if (job_ready !== 1'b0 || busy !== 1'b1 || mac_sel !== 1'b1)
      $display("FAIL bp_late_accept got=%b%b%b exp=011", job_ready, busy, mac_sel);
    else passed++;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_stream();
    int res_cyc; logic sel_ok, opr, bub_ok; logic [15:0] fab;
    int guard;
    job_valid = 1'b1;
    job_mode  = 1'b0;
    job_len   = 8'd4;
    step();
    job_valid = 1'b0;
    guard = 0;
    while (op_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    total++;
    if (op_ready !== 1'b1) $display("FAIL mid_reach_stream got=%b exp=1", op_ready); else passed++;
    op_valid = 1'b1; op_a = 8'd1; op_b = 8'd2;
    step();
    op_a = 8'd3; op_b = 8'd4;
    step();
    #3;
    rst = 1'b0;
    #1;
    total++;
    if ({job_ready, op_ready, busy, mac_clr_n, mac_sel, res_valid, res_mode} !== 7'b1000000)
      $display("FAIL mid_reset_ctrl got=%b exp=%b", {job_ready, op_ready, busy, mac_clr_n, mac_sel, res_valid, res_mode}, 7'b1000000);
    else passed++;
    total++;
    if ({mac_a, mac_b, res_data} !== 24'h0) $display("FAIL mid_reset_data got=%h exp=000000", {mac_a, mac_b, res_data});
    else passed++;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    tab_a[0] = 8'd9; tab_b[0] = 8'd9;
    run_job(1'b0, 8'd1, 64'h0, res_cyc, sel_ok, opr, bub_ok, fab);
    total++;
    if (res_cyc != 8) $display("FAIL post_reset_latency got=%0d exp=8", res_cyc); else passed++;
    total++;
    if (res_data !== 8'd81) $display("FAIL post_reset_data got=%0d exp=81", res_data); else passed++;
    accept_result();
  endtask

  task automatic test_max_len();
    int res_cyc; logic sel_ok, opr, bub_ok; logic [15:0] fab;
    for (int i = 0; i < 256; i++) begin
      tab_a[i] = 8'd1;
      tab_b[i] = 8'd1;
    end
    run_job(1'b0, 8'd255, 64'h0, res_cyc, sel_ok, opr, bub_ok, fab);
    total++;
    if (res_cyc != 262) $display("FAIL maxlen_latency got=%0d exp=262", res_cyc); else passed++;
    total++;
    if (res_data !== 8'd255) $display("FAIL maxlen_data got=%0d exp=255", res_data); else passed++;
    accept_result();
  endtask

  initial begin
    job_valid = 1'b0;
    job_mode  = 1'b0;
    job_len   = '0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    test_reset();
    test_fp8_basic();
    test_bubbles();
    test_fp4();
    test_len0();
    test_back_pressure();
    test_reset_mid_stream();
    test_max_len();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
